arty_axil_mem_responder: RTL and testbench

AXI4-Lite slave that answers read and write transactions from an on-chip block RAM. It is the responder end of the AXI4-Lite link that the BedRock-to-AXI4-Lite adapter drives. It stands in for the DDR3 block design so the FPGA host and adapter path can be brought up and regressed without the memory controller. It handles one transaction at a time, supports byte strobes, and returns responses with fixed latency.

---
 rtl/arty_axil_pkg.sv | 29 ++
 rtl/bsg_mem_1rw_sync_mask_write_byte.sv | 37 +++
 rtl/arty_axil_mem_responder.sv | 175 +++++++++++++++++
 tb/tb_arty_axil_mem_responder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arty_axil_pkg.sv
// Shared types and constants for the AXI4-Lite block-RAM responder.
package arty_axil_pkg;

  // Responder FSM states
  typedef enum logic [2:0] {
    e_idle,
    e_wait_w,
    e_wait_aw,
    e_bresp,
    e_rd,
    e_rresp
  } state_e;

  // AXI response codes
  localparam logic [1:0] resp_okay   = 2'b00;
  localparam logic [1:0] resp_slverr = 2'b10;
  localparam logic [1:0] resp_decerr = 2'b11;

  // Number of strobe bits (bytes) in a data beat
  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Number of address bits that select a byte within a data beat
  function automatic int unsigned byte_off_width(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous RAM with per-byte write enables; read data appears
// the cycle after a read is issued and holds until the next read.
module bsg_mem_1rw_sync_mask_write_byte
  import arty_axil_pkg::*;
#(
  parameter int unsigned els_p        = 1024,
  parameter int unsigned data_width_p = 64
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          v_i,
  input  logic                          w_i,
  input  logic [$clog2(els_p)-1:0]      addr_i,
  input  logic [data_width_p-1:0]       data_i,
  input  logic [data_width_p/8-1:0]     write_mask_i,
  output logic [data_width_p-1:0]       data_o
);

  localparam int unsigned mask_w = strb_width(data_width_p);

  logic [data_width_p-1:0] mem [els_p];

  // Contents are deliberately not cleared by reset
  logic unused_ok;
  assign unused_ok = reset_i;

  // Byte-masked write or registered read
  always_ff @(posedge clk_i) begin
    if (v_i & w_i) begin
      for (int unsigned i = 0; i < mask_w; i++) begin
        if (write_mask_i[i]) mem[addr_i][i*8 +: 8] <= data_i[i*8 +: 8];
      end
    end
    if (v_i & ~w_i) data_o <= mem[addr_i];
  end

endmodule

// File: rtl/arty_axil_mem_responder.sv
// AXI4-Lite slave backed by an on-chip byte-writable RAM. One transaction is
// in flight at a time; writes win a tie against reads.
// Optional: define ARTY_AXIL_MEM_DECERR_EN to answer addresses beyond the RAM
// with DECERR instead of letting them wrap.
module arty_axil_mem_responder
  import arty_axil_pkg::*;
#(
  parameter int unsigned axi_addr_width_p = 28,
  parameter int unsigned axi_data_width_p = 64,
  parameter int unsigned mem_els_p        = 1024
) (
  input  logic                          s_axi_clk,
  input  logic                          reset,
  input  logic [axi_addr_width_p-1:0]   awaddr_i,
  input  logic [2:0]                    awprot_i,
  input  logic                          awvalid_i,
  output logic                          awready_o,
  input  logic [axi_data_width_p-1:0]   wdata_i,
  input  logic [axi_data_width_p/8-1:0] wstrb_i,
  input  logic                          wvalid_i,
  output logic                          wready_o,
  output logic [1:0]                    bresp_o,
  output logic                          bvalid_o,
  input  logic                          bready_i,
  input  logic [axi_addr_width_p-1:0]   araddr_i,
  input  logic [2:0]                    arprot_i,
  input  logic                          arvalid_i,
  output logic                          arready_o,
  output logic [axi_data_width_p-1:0]   rdata_o,
  output logic [1:0]                    rresp_o,
  output logic                          rvalid_o,
  input  logic                          rready_i
);

  localparam int unsigned strb_w = strb_width(axi_data_width_p);
  localparam int unsigned off_w  = byte_off_width(axi_data_width_p);
  localparam int unsigned idx_w  = $clog2(mem_els_p);

  state_e                      state_r, state_n;
  logic [axi_addr_width_p-1:0] addr_r, wr_addr;
  logic [axi_data_width_p-1:0] data_r, wr_data, ram_q;
  logic [strb_w-1:0]           strb_r, wr_strb;
  logic                        wr_go, rd_go, wr_err, rd_err, ram_v;
  logic [idx_w-1:0]            ram_addr;

  // Write operands come from the live channel or the half captured earlier
  always_comb begin
    wr_addr = (state_r == e_wait_w)  ? addr_r : awaddr_i;
    wr_data = (state_r == e_wait_aw) ? data_r : wdata_i;
    wr_strb = (state_r == e_wait_aw) ? strb_r : wstrb_i;
  end

`ifdef ARTY_AXIL_MEM_DECERR_EN
  // Any set bit above the word-index field puts the access past the RAM
  assign wr_err = (wr_addr >> (off_w + idx_w)) != '0;
  assign rd_err = (addr_r  >> (off_w + idx_w)) != '0;
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  // Protection bits and high/byte-offset address bits carry no meaning here
  logic unused_ok;
  assign unused_ok = ^{awprot_i, arprot_i, araddr_i, addr_r, wr_addr};

  // State register
  always_ff @(posedge s_axi_clk) begin
    if (reset) state_r <= e_idle;
    else       state_r <= state_n;
  end

  // Next state, channel readies and RAM commands
  always_comb begin
    state_n   = state_r;
    awready_o = 1'b0;
    wready_o  = 1'b0;
    arready_o = 1'b0;
    wr_go     = 1'b0;
    rd_go     = 1'b0;
    unique case (state_r)
      e_idle: begin
        awready_o = 1'b1;
        wready_o  = 1'b1;
        arready_o = ~awvalid_i & ~wvalid_i;
        if (awvalid_i & wvalid_i) begin
          wr_go   = 1'b1;
          state_n = e_bresp;
        end else if (awvalid_i) begin
          state_n = e_wait_w;
        end else if (wvalid_i) begin
          state_n = e_wait_aw;
        end else if (arvalid_i) begin
          rd_go   = 1'b1;
          state_n = e_rd;
        end
      end
      e_wait_w: begin
        wready_o = 1'b1;
        if (wvalid_i) begin
          wr_go   = 1'b1;
          state_n = e_bresp;
        end
      end
      e_wait_aw: begin
        awready_o = 1'b1;
        if (awvalid_i) begin
          wr_go   = 1'b1;
          state_n = e_bresp;
        end
      end
      e_bresp: if (bready_i) state_n = e_idle;
      e_rd:    state_n = e_rresp;
      e_rresp: if (rready_i) state_n = e_idle;
      default: state_n = e_idle;
    endcase
    if (reset) begin
      awready_o = 1'b0;
      wready_o  = 1'b0;
      arready_o = 1'b0;
      wr_go     = 1'b0;
      rd_go     = 1'b0;
      state_n   = e_idle;
    end
  end

  // Hold whichever half of a split write arrived first, or the read address
  always_ff @(posedge s_axi_clk) begin
    if (state_r == e_idle) begin
      if (awvalid_i)      addr_r <= awaddr_i;
      else if (arvalid_i) addr_r <= araddr_i;
      if (wvalid_i) begin
        data_r <= wdata_i;
        strb_r <= wstrb_i;
      end
    end
  end

  // Out-of-range writes never touch the RAM; reads use the live AR address
  assign ram_v    = (wr_go & ~wr_err) | rd_go;
  assign ram_addr = wr_go ? wr_addr[off_w +: idx_w] : araddr_i[off_w +: idx_w];

  bsg_mem_1rw_sync_mask_write_byte #(
    .els_p        (mem_els_p),
    .data_width_p (axi_data_width_p)
  ) ram (
    .clk_i        (s_axi_clk),
    .reset_i      (reset),
    .v_i          (ram_v),
    .w_i          (wr_go),
    .addr_i       (ram_addr),
    .data_i       (wr_data),
    .write_mask_i (wr_strb),
    .data_o       (ram_q)
  );

  // Registered response channels; payload holds until the handshake
  always_ff @(posedge s_axi_clk) begin
    if (reset) begin
      bvalid_o <= 1'b0;
      rvalid_o <= 1'b0;
      bresp_o  <= resp_okay;
      rresp_o  <= resp_okay;
      rdata_o  <= '0;
    end else begin
      bvalid_o <= (state_n == e_bresp);
      rvalid_o <= (state_n == e_rresp);
      if (wr_go) bresp_o <= wr_err ? resp_decerr : resp_okay;
      if (state_r == e_rd) begin
        rdata_o <= rd_err ? '0 : ram_q;
        rresp_o <= rd_err ? resp_decerr : resp_okay;
      end
    end
  end

endmodule

// File: tb/tb_arty_axil_mem_responder.sv
// Randomised scoreboard bench for arty_axil_mem_responder.
module tb_arty_axil_mem_responder;

  localparam int unsigned aw_w   = 28;
  localparam int unsigned els    = 1024;
  localparam int unsigned nbytes = 8;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  logic            s_axi_clk = 1'b0;
  logic            reset;
  logic [aw_w-1:0] awaddr, araddr;
  logic [2:0]      awprot, arprot;
  logic            awvalid, wvalid, arvalid, bready, rready;
  logic [63:0]     wdata;
  logic [7:0]      wstrb;
  logic            awready_o, wready_o, arready_o, bvalid_o, rvalid_o;
  logic [1:0]      bresp_o, rresp_o;
  logic [63:0]     rdata_o;

  always #5 s_axi_clk = ~s_axi_clk;

  arty_axil_mem_responder dut (
    .s_axi_clk (s_axi_clk), .reset (reset),
    .awaddr_i  (awaddr),    .awprot_i (awprot), .awvalid_i (awvalid), .awready_o (awready_o),
    .wdata_i   (wdata),     .wstrb_i  (wstrb),  .wvalid_i  (wvalid),  .wready_o  (wready_o),
    .bresp_o   (bresp_o),   .bvalid_o (bvalid_o), .bready_i (bready),
    .araddr_i  (araddr),    .arprot_i (arprot), .arvalid_i (arvalid), .arready_o (arready_o),
    .rdata_o   (rdata_o),   .rresp_o  (rresp_o), .rvalid_o (rvalid_o), .rready_i (rready)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          hold_cnt = 0;
  logic [63:0] mdl [els];
  logic [1:0]  bq [$];
  r_exp_t      rq [$];
  bit          b_stall = 1'b0;
  bit          r_stall = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: byte-addressed memory seen as 8-byte words
  function automatic bit oob(input logic [aw_w-1:0] a);
`ifdef ARTY_AXIL_MEM_DECERR_EN
    return (int'(a) / int'(nbytes)) >= int'(els);
`else
    return (a == a) ? 1'b0 : 1'b1;
`endif
  endfunction

  function automatic int idx_of(input logic [aw_w-1:0] a);
    return (int'(a) / int'(nbytes)) % int'(els);
  endfunction

  function automatic logic [1:0] model_write(input logic [aw_w-1:0] a, input logic [63:0] d,
                                             input logic [7:0] s);
    if (oob(a)) return 2'b11;
    for (int b = 0; b < 8; b++) if (s[b]) mdl[idx_of(a)][b*8 +: 8] = d[b*8 +: 8];
    return 2'b00;
  endfunction

  // Random back-pressure on B and R, with an optional forced stall window
  initial begin
    bready = 1'b0;
    rready = 1'b0;
    forever begin
      @(posedge s_axi_clk);
      #1;
      if (hold_cnt > 0) begin
        bready = 1'b0;
        rready = 1'b0;
        hold_cnt--;
      end else begin
        bready = ($urandom_range(0, 3) != 0);
        rready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: compare every presented response against the scoreboard head
  always @(negedge s_axi_clk) begin
    if (reset) begin
      b_stall = 1'b0;
      r_stall = 1'b0;
    end else begin
      if (b_stall) chk("bvalid_hold", 64'(bvalid_o), 64'(1));
      if (r_stall) chk("rvalid_hold", 64'(rvalid_o), 64'(1));
      if (bvalid_o) begin
        if (bq.size() == 0) chk("bvalid_spurious", 64'(bvalid_o), 64'(0));
        else begin
          chk("bresp", 64'(bresp_o), 64'(bq[0]));
          if (bready) void'(bq.pop_front());
        end
      end
      if (rvalid_o) begin
        if (rq.size() == 0) chk("rvalid_spurious", 64'(rvalid_o), 64'(0));
        else begin
          chk("rdata", rdata_o, rq[0].data);
          chk("rresp", 64'(rresp_o), 64'(rq[0].resp));
          if (rready) void'(rq.pop_front());
        end
      end
      b_stall = bvalid_o && !bready;
      r_stall = rvalid_o && !rready;
    end
  end

  // Wait for all expected responses to be consumed (bounded)
  task automatic drain();
    int n = 0;
    do begin
      @(posedge s_axi_clk);
      n++;
    end while ((bq.size() != 0 || rq.size() != 0) && n < 200);
    chk("drain_pending", 64'(bq.size() + rq.size()), 64'(0));
    bq.delete();
    rq.delete();
    #1;
  endtask

  task automatic do_write(input logic [aw_w-1:0] a, input logic [63:0] d, input logic [7:0] s,
                          input int aw_dly, input int w_dly);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit faw, fw;
    int cyc = 0;
    logic [2:0] exp_rdy;
    bq.push_back(model_write(a, d, s));
    awaddr = a;
    wdata  = d;
    wstrb  = s;
    while (!(aw_done && w_done) && cyc < 50) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      if (aw_done)     exp_rdy = 3'b010;
      else if (w_done) exp_rdy = 3'b100;
      else             exp_rdy = {2'b11, !(awvalid || wvalid)};
      @(negedge s_axi_clk);
      chk("ready_write", 64'({awready_o, wready_o, arready_o}), 64'(exp_rdy));
      faw = awvalid && awready_o;
      fw  = wvalid && wready_o;
      @(posedge s_axi_clk);
      #1;
      aw_done |= faw;
      w_done  |= fw;
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    chk("write_accept", 64'({aw_done, w_done}), 64'(2'b11));
    @(negedge s_axi_clk);
    chk("b_latency", 64'(bvalid_o), 64'(1));
    drain();
  endtask

  task automatic do_read(input logic [aw_w-1:0] a);
    r_exp_t e;
    bit fired = 1'b0;
    int cyc = 0;
    e.resp = oob(a) ? 2'b11 : 2'b00;
    e.data = oob(a) ? 64'd0 : mdl[idx_of(a)];
    rq.push_back(e);
    araddr  = a;
    arvalid = 1'b1;
    while (!fired && cyc < 50) begin
      @(negedge s_axi_clk);
      chk("ready_read", 64'({awready_o, wready_o, arready_o}), 64'(3'b111));
      fired = arready_o;
      @(posedge s_axi_clk);
      #1;
      cyc++;
    end
    arvalid = 1'b0;
    chk("read_accept", 64'(fired), 64'(1));
    @(negedge s_axi_clk);
    chk("r_latency_t1", 64'(rvalid_o), 64'(0));
    @(posedge s_axi_clk);
    #1;
    @(negedge s_axi_clk);
    chk("r_latency_t2", 64'(rvalid_o), 64'(1));
    drain();
  endtask

  // Simultaneous AW, W and AR: write must win, read follows
  task automatic do_tie(input logic [aw_w-1:0] a, input logic [63:0] d);
    r_exp_t e;
    bit fired = 1'b0;
    int cyc = 0;
    bq.push_back(model_write(a, d, 8'hFF));
    e.resp = oob(a) ? 2'b11 : 2'b00;
    e.data = oob(a) ? 64'd0 : mdl[idx_of(a)];
    rq.push_back(e);
    awaddr = a; wdata = d; wstrb = 8'hFF; araddr = a;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge s_axi_clk);
    chk("ready_tie", 64'({awready_o, wready_o, arready_o}), 64'(3'b110));
    @(posedge s_axi_clk);
    #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    while (!fired && cyc < 200) begin
      @(negedge s_axi_clk);
      fired = arready_o;
      @(posedge s_axi_clk);
      #1;
      cyc++;
    end
    arvalid = 1'b0;
    chk("tie_read_accept", 64'(fired), 64'(1));
    drain();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: run exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    awaddr = '0; araddr = '0; awprot = 3'd0; arprot = 3'd0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    wdata = '0; wstrb = '0;

    // Reset: outputs quiet even with every request valid
    repeat (2) @(posedge s_axi_clk);
    #1;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge s_axi_clk);
    chk("rst_readies", 64'({awready_o, wready_o, arready_o}), 64'(0));
    chk("rst_valids", 64'({bvalid_o, rvalid_o}), 64'(0));
    chk("rst_rdata", rdata_o, 64'(0));
    chk("rst_resps", 64'({bresp_o, rresp_o}), 64'(0));
    @(posedge s_axi_clk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    reset = 1'b0;
    @(negedge s_axi_clk);
    chk("idle_readies", 64'({awready_o, wready_o, arready_o}), 64'(3'b111));
    @(posedge s_axi_clk);
    #1;

    // Give every word a known value
    for (int i = 0; i < int'(els); i++)
      do_write(aw_w'(i * int'(nbytes)), {$urandom, $urandom}, 8'hFF, 0, 0);

    // Directed cases
    do_write(28'h10, 64'hDEADBEEF_01234567, 8'hFF, 0, 0);
    do_read(28'h10);
    do_write(28'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0);
    do_write(28'h20, 64'h0, 8'h0F, 0, 0);
    do_read(28'h20);
    do_write(28'h08, 64'h55, 8'hFF, 0, 3);
    do_write(28'h18, 64'h66, 8'hFF, 2, 0);
    do_read(28'h08);
    do_read(28'h18);
    do_tie(28'h30, 64'hCAFE_F00D_1234_5678);
    hold_cnt = 8;
    do_write(28'h48, 64'h0123_4567_89AB_CDEF, 8'hA5, 0, 0);
    hold_cnt = 9;
    do_read(28'h48);
    do_write(aw_w'(els * nbytes), 64'h1111_2222_3333_4444, 8'hFF, 0, 0);
    do_read(aw_w'(els * nbytes));
    do_read(28'h0);

    // Reset during a half-finished write abandons it
    awaddr = 28'h40; awvalid = 1'b1;
    @(negedge s_axi_clk);
    chk("ready_aw_only", 64'({awready_o, wready_o, arready_o}), 64'(3'b110));
    @(posedge s_axi_clk);
    #1;
    awvalid = 1'b0;
    @(negedge s_axi_clk);
    chk("ready_wait_w", 64'({awready_o, wready_o, arready_o}), 64'(3'b010));
    @(posedge s_axi_clk);
    #1;
    reset = 1'b1;
    @(posedge s_axi_clk);
    #1;
    @(negedge s_axi_clk);
    chk("rst_mid", 64'({awready_o, wready_o, arready_o, bvalid_o, rvalid_o}), 64'(0));
    @(posedge s_axi_clk);
    #1;
    reset = 1'b0;
    @(negedge s_axi_clk);
    chk("rst_mid_idle", 64'({awready_o, wready_o, arready_o}), 64'(3'b111));
    @(posedge s_axi_clk);
    #1;
    do_read(28'h40);

    // Random mix of reads and writes
    for (int t = 0; t < 300; t++) begin
      logic [aw_w-1:0] a;
      if ($urandom_range(0, 9) == 0) a = aw_w'($urandom);
      else a = aw_w'(($urandom_range(0, els - 1) << 3) | $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1)
        do_write(a, {$urandom, $urandom}, 8'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      else
        do_read(a);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
